asteroids_stage_ctrl: RTL
=========================

// Module: asteroids_stage_ctrl
// PURPOSE
//  Stage controller for the asteroids special stage; sits directly upstream of the N asteroids_move instances.
//  Releases asteroids one at a time by driving each instance's active-low reset.
//  Consumes their sticky asteroidIsHit flags to count destroyed asteroids.
//  Runs the stage timer and decides win/lose for the top-level game FSM.
// PARAMETERS
//  ASTEROID_COUNT  8    number of asteroids_move instances controlled (N, 1..15)
//  STAGE_FRAMES    900  stage length in frames (30 s at 30 Hz); 1..65535
//  RELEASE_FRAMES  15   frames between consecutive asteroid releases; >=1
// PORTS
//  clk              in   1   system clock, single domain
//  resetN           in   1   asynchronous active-low reset
//  startOfFrame     in   1   one-cycle pulse at frame start (30 Hz)
//  start_stage      in   1   one-cycle pulse from game FSM: begin stage
//  player_hit       in   1   player collided with an asteroid (level or pulse)
//  asteroidIsHit    in   N   sticky hit flags, bit i from asteroid i
//  asteroid_resetN  out  N   per-asteroid active-low reset; top ANDs each bit with resetN
//  destroyed_count  out  4   asteroids destroyed this stage
//  frames_left      out  16  remaining stage frames
//  stage_active     out  1   1 in RELEASING or RUNNING
//  stage_won        out  1   1 in WON
//  stage_lost       out  1   1 in LOST
// BEHAVIOUR
//  Reset state:
//  - State IDLE. asteroid_resetN=0, destroyed_count=0, frames_left=0.
//  - stage_active=0, stage_won=0, stage_lost=0.
//  - All outputs are registered. Each response appears one clk after the input that causes it is sampled.
//  States: IDLE, RELEASING, RUNNING, WON, LOST.
//  Start:
//  - start_stage in IDLE/WON/LOST -> RELEASING, with destroyed_count=0, frames_left=STAGE_FRAMES, release_idx=0, release_timer=0.
//  - start_stage is ignored in RELEASING and RUNNING.
//  RELEASING, on each startOfFrame:
//  - If release_timer==0: asteroid_resetN[release_idx]<=1, release_idx++, release_timer<=RELEASE_FRAMES-1.
//  - Otherwise release_timer--.
//  - When the last asteroid is released, go to RUNNING on that same edge.
//  - Asteroid 0 is released on the first startOfFrame after start.
//  Timer:
//  - In RELEASING and RUNNING, each startOfFrame decrements frames_left.
//  - frames_left never wraps below 0.
//  - If frames_left==1 when startOfFrame arrives, frames_left becomes 0 and the state goes to WON on that edge.
//  Hit counting:
//  - hit_edge[i] = asteroidIsHit[i] & ~hit_prev[i] & asteroid_resetN[i].
//  - hit_prev is cleared for every asteroid held in reset.
//  - destroyed_count += popcount(hit_edge) each clk, in RELEASING and RUNNING only.
//  - A flag held high counts exactly once.
//  - Hits on unreleased asteroids are masked.
//  End conditions, evaluated each clk in RELEASING/RUNNING; priority LOST > WON:
//  - player_hit=1 -> LOST.
//  - Otherwise, next destroyed_count==N -> WON.
//  - Otherwise, timer expiry -> WON.
//  WON/LOST:
//  - On entry, all asteroid_resetN<=0, which freezes and re-inits the asteroids.
//  - destroyed_count and frames_left hold their values for score display.
//  - The state stays WON/LOST until start_stage.
//  Simultaneous events:
//  - A hit and the end condition on the same clk: the hit is still counted.
//  - startOfFrame and start_stage on the same clk in IDLE: the start takes effect and that frame is not counted.
//  - resetN low mid-stage: immediate return to the reset state, independent of clk.
// TESTING (N=4, RELEASE_FRAMES=2, STAGE_FRAMES=20)
//  1. Reset, then 5 startOfFrame pulses without start_stage -> outputs stay at reset values, asteroid_resetN=4'b0000.
//  2. start_stage, then startOfFrame pulses ->
//     - asteroid_resetN=0001 after frame 1, 0011 after frame 3, 0111 after frame 5, 1111 after frame 7;
//     - stage_active=1, state RUNNING;
//     - frames_left=13 after frame 7.
//  3. In RUNNING, raise and hold asteroidIsHit bits 0, 2, 1, 3 in turn ->
//     - destroyed_count steps 1, 2, 3, 4 (bit 0 held 10 clks counts once);
//     - after the 4th hit: stage_won=1, asteroid_resetN=0000.
//  4. No hits, 20 startOfFrame pulses -> frames_left=0, stage_won=1, destroyed_count=0; a 21st pulse changes nothing.
//  5. player_hit on the same clk as the 4th hit edge -> stage_lost=1, stage_won=0, destroyed_count=4.
//  6. Edge cases:
//     - asteroidIsHit[3]=1 before asteroid 3 is released -> not counted.
//     - start_stage in RUNNING -> ignored.
//     - resetN low in RUNNING -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/asteroids_stage_ctrl.sv
// Stage controller for the asteroids special stage.
// Releases the asteroid movers one at a time, counts destroyed asteroids from their
// sticky hit flags, runs the stage frame timer and reports win/lose to the game FSM.
//
//  state        | meaning
//  -------------+-----------------------------------------------------------
//  S_IDLE       | after reset, waiting for start_stage_i
//  S_RELEASING  | stage running, asteroids still being released one per slot
//  S_RUNNING    | stage running, all asteroids released
//  S_WON        | all asteroids destroyed or timer expired; asteroids held in reset
//  S_LOST       | player was hit; asteroids held in reset
module asteroids_stage_ctrl #(
    parameter int ASTEROID_COUNT = 8,
    parameter int STAGE_FRAMES   = 900,
    parameter int RELEASE_FRAMES = 15
) (
    input  logic                      clk_i,
    input  logic                      resetN_i,
    input  logic                      startOfFrame_i,
    input  logic                      start_stage_i,
    input  logic                      player_hit_i,
    input  logic [ASTEROID_COUNT-1:0] asteroidIsHit_i,
    output logic [ASTEROID_COUNT-1:0] asteroid_resetN_o,
    output logic [3:0]                destroyed_count_o,
    output logic [15:0]               frames_left_o,
    output logic                      stage_active_o,
    output logic                      stage_won_o,
    output logic                      stage_lost_o
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RELEASING = 3'd1,
        S_RUNNING   = 3'd2,
        S_WON       = 3'd3,
        S_LOST      = 3'd4
    } state_t;

    localparam logic [15:0] STAGE_LOAD = 16'(STAGE_FRAMES);
    localparam logic [15:0] REL_RELOAD = 16'(RELEASE_FRAMES - 1);
    localparam logic [3:0]  N_CNT      = 4'(ASTEROID_COUNT);
    localparam logic [3:0]  LAST_IDX   = 4'(ASTEROID_COUNT - 1);

    state_t                    state_q, state_d;
    logic [ASTEROID_COUNT-1:0] ares_q, ares_d;
    logic [ASTEROID_COUNT-1:0] hit_prev_q, hit_prev_d;
    logic [3:0]                count_q, count_d;
    logic [15:0]               frames_q, frames_d;
    logic [3:0]                rel_idx_q, rel_idx_d;
    logic [15:0]               rel_timer_q, rel_timer_d;

    logic [ASTEROID_COUNT-1:0] hit_edge;
    logic [3:0]                hit_cnt;
    logic [3:0]                count_sum;
    logic                      in_stage;
    logic                      timer_expire;
    logic                      last_release;

    // Hit edge detection, masked to released asteroids, and the running destroyed total
    always_comb begin
        hit_edge  = asteroidIsHit_i & ~hit_prev_q & ares_q;
        hit_cnt   = '0;
        for (int i = 0; i < ASTEROID_COUNT; i++) begin
            hit_cnt = hit_cnt + 4'(hit_edge[i]);
        end
        count_sum    = count_q + hit_cnt;
        in_stage     = (state_q == S_RELEASING) || (state_q == S_RUNNING);
        timer_expire = in_stage && startOfFrame_i && (frames_q == 16'd1);
        last_release = (state_q == S_RELEASING) && startOfFrame_i &&
                       (rel_timer_q == 16'd0) && (rel_idx_q == LAST_IDX);
    end

    // State register
    always_ff @(posedge clk_i or negedge resetN_i) begin
        if (!resetN_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a player hit outranks any win condition
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_WON, S_LOST: begin
                if (start_stage_i) state_d = S_RELEASING;
            end
            S_RELEASING, S_RUNNING: begin
                if (player_hit_i)             state_d = S_LOST;
                else if (count_sum == N_CNT)  state_d = S_WON;
                else if (timer_expire)        state_d = S_WON;
                else if (last_release)        state_d = S_RUNNING;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next values: release sequencing, frame timer, hit counting
    always_comb begin
        ares_d      = ares_q;
        count_d     = count_q;
        frames_d    = frames_q;
        rel_idx_d   = rel_idx_q;
        rel_timer_d = rel_timer_q;
        // Asteroids held in reset forget any previous flag so a fresh release starts clean
        hit_prev_d  = asteroidIsHit_i & ares_q;

        if (start_stage_i && !in_stage) begin
            // A frame pulse arriving with the start is deliberately not counted
            ares_d      = '0;
            count_d     = '0;
            frames_d    = STAGE_LOAD;
            rel_idx_d   = '0;
            rel_timer_d = '0;
        end else if (in_stage) begin
            count_d = count_sum;
            if (startOfFrame_i) begin
                if (frames_q != 16'd0) frames_d = frames_q - 16'd1;
                if (state_q == S_RELEASING) begin
                    if (rel_timer_q == 16'd0) begin
                        for (int i = 0; i < ASTEROID_COUNT; i++) begin
                            if (4'(i) == rel_idx_q) ares_d[i] = 1'b1;
                        end
                        rel_idx_d   = rel_idx_q + 4'd1;
                        rel_timer_d = REL_RELOAD;
                    end else begin
                        rel_timer_d = rel_timer_q - 16'd1;
                    end
                end
            end
            if ((state_d == S_WON) || (state_d == S_LOST)) ares_d = '0;
        end
    end

    // Datapath registers
    always_ff @(posedge clk_i or negedge resetN_i) begin
        if (!resetN_i) begin
            ares_q      <= '0;
            hit_prev_q  <= '0;
            count_q     <= '0;
            frames_q    <= '0;
            rel_idx_q   <= '0;
            rel_timer_q <= '0;
        end else begin
            ares_q      <= ares_d;
            hit_prev_q  <= hit_prev_d;
            count_q     <= count_d;
            frames_q    <= frames_d;
            rel_idx_q   <= rel_idx_d;
            rel_timer_q <= rel_timer_d;
        end
    end

    // Outputs decoded from registered state
    always_comb begin
        asteroid_resetN_o = ares_q;
        destroyed_count_o = count_q;
        frames_left_o     = frames_q;
        stage_active_o    = (state_q == S_RELEASING) || (state_q == S_RUNNING);
        stage_won_o       = (state_q == S_WON);
        stage_lost_o      = (state_q == S_LOST);
    end

endmodule
